// File: rtl/pcs_scrambler_64b.sv
// pcs_scrambler_64b
// Transmit-side 64b/66b PCS scrambler, self-synchronous, g(x) = x^58 + x^39 + 1.
// The 64-bit payload is scrambled; the 2-bit sync header passes through unchanged.
// There is one registered output stage with valid/ready on both sides.
// Optional feature macro: SCR_TEST_PATTERN_EN. When it is defined, the block
// gains a test_mode input that sources the scrambled-zeros test pattern.
module pcs_scrambler_64b #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                  CLK,
  input  logic                  rst,
`ifdef SCR_TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  input  logic [1:0]            hdr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [1:0]            hdr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  hdr_err,
  output logic [15:0]           hdr_err_cnt
);

  // The unrolled scrambler below is written for exactly 64 bits.
  if (DATA_WIDTH != 64) begin : g_bad_width
    $error("pcs_scrambler_64b: DATA_WIDTH must be 64");
  end

  // A sync header is legal only as 2'b01 or 2'b10.
  function automatic logic f_hdr_bad(input logic [1:0] hdr);
    f_hdr_bad = (hdr == 2'b00) || (hdr == 2'b11);
  endfunction

  logic [57:0]           r_state;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [1:0]            r_hdr_out;
  logic                  r_out_valid;
  logic                  r_hdr_err;
  logic [15:0]           r_hdr_err_cnt;

  logic                  w_slot_free;
  logic                  w_src_valid;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic [1:0]            w_src_hdr;
  logic                  w_accept;
  logic                  w_hdr_bad;
  logic [63:0]           w_scr;

  // The output slot can take a block when it is empty or is being drained.
  assign w_slot_free = !r_out_valid || out_ready;

`ifdef SCR_TEST_PATTERN_EN
  // In test mode an internal source offers an all-zero block with header 2'b10.
  assign w_src_valid = test_mode ? 1'b1 : in_valid;
  assign w_src_data  = test_mode ? {DATA_WIDTH{1'b0}} : data_in;
  assign w_src_hdr   = test_mode ? 2'b10 : hdr_in;
  assign in_ready    = test_mode ? 1'b0 : w_slot_free;
`else
  assign w_src_valid = in_valid;
  assign w_src_data  = data_in;
  assign w_src_hdr   = hdr_in;
  assign in_ready    = w_slot_free;
`endif

  assign w_accept  = w_src_valid && w_slot_free;
  assign w_hdr_bad = f_hdr_bad(w_src_hdr);

  // Unrolled scrambler: s_i = d_i ^ s_(i-39) ^ s_(i-58); negative taps come from r_state.
  always_comb begin
    logic [63:0] v_s;
    v_s = 64'h0;
    for (int i = 0; i < 39; i++) begin
      v_s[i] = w_src_data[i] ^ r_state[i + 19] ^ r_state[i];
    end
    for (int i = 39; i < 58; i++) begin
      v_s[i] = w_src_data[i] ^ v_s[i - 39] ^ r_state[i];
    end
    for (int i = 58; i < 64; i++) begin
      v_s[i] = w_src_data[i] ^ v_s[i - 39] ^ v_s[i - 58];
    end
    w_scr = v_s;
  end

  // Scrambler state advances only on an accepted beat, keeping the top 58 scrambled bits.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (w_accept) begin
      r_state <= w_scr[63:6];
    end
  end

  // Output payload/header register loads on accept and holds under backpressure.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_data_out <= {DATA_WIDTH{1'b0}};
      r_hdr_out  <= 2'b00;
    end else if (w_accept) begin
      r_data_out <= w_scr;
      r_hdr_out  <= w_src_hdr;
    end
  end

  // Output valid follows the source whenever the slot is free, so pop and push share an edge.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else if (w_slot_free) begin
      r_out_valid <= w_src_valid;
    end
  end

  // Bad-header pulse lines up with the beat that carries the block to the output.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_hdr_err <= 1'b0;
    end else begin
      r_hdr_err <= w_accept && w_hdr_bad;
    end
  end

  // Saturating count of accepted bad headers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_hdr_err_cnt <= 16'h0000;
    end else if (w_accept && w_hdr_bad && (r_hdr_err_cnt != 16'hFFFF)) begin
      r_hdr_err_cnt <= r_hdr_err_cnt + 16'd1;
    end
  end

  assign data_out    = r_data_out;
  assign hdr_out     = r_hdr_out;
  assign out_valid   = r_out_valid;
  assign hdr_err     = r_hdr_err;
  assign hdr_err_cnt = r_hdr_err_cnt;

endmodule

// File: tb/tb_pcs_scrambler_64b.sv
// Directed testbench for pcs_scrambler_64b.
module tb_pcs_scrambler_64b;

  localparam logic [57:0] SEED_V    = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZERO_SCR  = 64'h03FF_FF80_0000_0000;

  logic        CLK = 1'b0;
  logic        rst;
  logic [1:0]  hdr_in;
  logic [63:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  hdr_out;
  logic [63:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        hdr_err;
  logic [15:0] hdr_err_cnt;

  int checks = 0;
  int errors = 0;

  logic [57:0] m_state;
  logic [63:0] exp_a, exp_b, exp_c, exp_d;

  always #5 CLK = ~CLK;

  pcs_scrambler_64b dut (
    .CLK         (CLK),
    .rst         (rst),
`ifdef SCR_TEST_PATTERN_EN
    .test_mode   (1'b0),
`endif
    .hdr_in      (hdr_in),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .hdr_out     (hdr_out),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .hdr_err     (hdr_err),
    .hdr_err_cnt (hdr_err_cnt)
  );

  // Bit-serial reference: m_state[57] is the newest scrambled bit, m_state[0] the oldest.
  task automatic model_scr(input logic [63:0] d, output logic [63:0] s);
    logic b;
    s = 64'h0;
    for (int i = 0; i < 64; i++) begin
      b = d[i] ^ m_state[19] ^ m_state[0];
      s[i] = b;
      m_state = {b, m_state[57:1]};
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    hdr_in    = 2'b00;
    data_in   = 64'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    m_state   = SEED_V;
    tick();
    tick();

    // Reset state
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_data_out", data_out, 64'h0);
    chk("rst_hdr_out", {62'h0, hdr_out}, 64'h0);
    chk("rst_hdr_err", {63'h0, hdr_err}, 64'h0);
    chk("rst_cnt", {48'h0, hdr_err_cnt}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    rst = 1'b0;
    tick();

    // First zero block from SEED
    hdr_in = 2'b10; data_in = 64'h0; in_valid = 1'b1;
    model_scr(64'h0, exp_a);
    tick();
    in_valid = 1'b0;
    chk("zero_valid", {63'h0, out_valid}, 64'h1);
    chk("zero_hdr", {62'h0, hdr_out}, 64'h2);
    chk("zero_data", data_out, ZERO_SCR);
    chk("zero_model", exp_a, ZERO_SCR);
    chk("zero_no_err", {63'h0, hdr_err}, 64'h0);
    tick();
    chk("bubble_valid", {63'h0, out_valid}, 64'h0);

    // Backpressure stream A, B (held), C
    hdr_in = 2'b01; data_in = 64'h0123_4567_89AB_CDEF; in_valid = 1'b1;
    model_scr(data_in, exp_a);
    tick();
    chk("bp_a_data", data_out, exp_a);
    out_ready = 1'b0;
    hdr_in = 2'b10; data_in = 64'hFFFF_0000_A5A5_5A5A;
    model_scr(data_in, exp_b);
    #1;
    chk("bp_in_ready0", {63'h0, in_ready}, 64'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_data", data_out, exp_a);
      chk("bp_hold_valid", {63'h0, out_valid}, 64'h1);
      chk("bp_hold_ready", {63'h0, in_ready}, 64'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'h0, in_ready}, 64'h1);
    tick();
    chk("bp_b_data", data_out, exp_b);
    chk("bp_b_hdr", {62'h0, hdr_out}, 64'h2);
    data_in = 64'h8000_0000_0000_0001;
    model_scr(data_in, exp_c);
    tick();
    chk("bp_c_data", data_out, exp_c);
    chk("bp_c_valid", {63'h0, out_valid}, 64'h1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", {63'h0, out_valid}, 64'h0);

    // Header errors: 00, 11, 01
    in_valid = 1'b1;
    hdr_in = 2'b00; data_in = 64'hDEAD_BEEF_0000_1111;
    model_scr(data_in, exp_a);
    tick();
    chk("h00_err", {63'h0, hdr_err}, 64'h1);
    chk("h00_hdr", {62'h0, hdr_out}, 64'h0);
    chk("h00_data", data_out, exp_a);
    hdr_in = 2'b11; data_in = 64'h1234_0000_FFFF_0042;
    model_scr(data_in, exp_b);
    tick();
    chk("h11_err", {63'h0, hdr_err}, 64'h1);
    chk("h11_hdr", {62'h0, hdr_out}, 64'h3);
    chk("h11_data", data_out, exp_b);
    hdr_in = 2'b01; data_in = 64'h0F0F_F0F0_3C3C_C3C3;
    model_scr(data_in, exp_c);
    tick();
    chk("h01_err", {63'h0, hdr_err}, 64'h0);
    chk("h01_hdr", {62'h0, hdr_out}, 64'h1);
    chk("h01_data", data_out, exp_c);
    chk("hdr_cnt2", {48'h0, hdr_err_cnt}, 64'h2);
    in_valid = 1'b0;
    tick();
    chk("hdr_err_idle", {63'h0, hdr_err}, 64'h0);

    // Saturation: preload near the top, then three bad headers
    force dut.r_hdr_err_cnt = 16'hFFFD;
    #1;
    release dut.r_hdr_err_cnt;
    #1;
    chk("sat_preload", {48'h0, hdr_err_cnt}, 64'hFFFD);
    in_valid = 1'b1; hdr_in = 2'b11; data_in = 64'h0;
    model_scr(data_in, exp_a);
    tick();
    chk("sat_cnt1", {48'h0, hdr_err_cnt}, 64'hFFFE);
    model_scr(data_in, exp_a);
    tick();
    chk("sat_cnt2", {48'h0, hdr_err_cnt}, 64'hFFFF);
    model_scr(data_in, exp_a);
    tick();
    chk("sat_cnt3", {48'h0, hdr_err_cnt}, 64'hFFFF);
    chk("sat_data", data_out, exp_a);

    // Mid-stream reset while out_valid = 1
    hdr_in = 2'b10; data_in = 64'h5555_AAAA_5555_AAAA;
    tick();
    in_valid = 1'b0;
    chk("mid_pre_valid", {63'h0, out_valid}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_async_data", data_out, 64'h0);
    chk("mid_async_cnt", {48'h0, hdr_err_cnt}, 64'h0);
    tick();
    rst = 1'b0;
    m_state = SEED_V;
    tick();
    in_valid = 1'b1; hdr_in = 2'b10; data_in = 64'h0;
    model_scr(64'h0, exp_d);
    tick();
    chk("post_rst_zero", data_out, ZERO_SCR);
    model_scr(64'h0, exp_d);
    tick();
    in_valid = 1'b0;
    chk("post_rst_zero2", data_out, exp_d);
    chk("post_rst_hdr", {62'h0, hdr_out}, 64'h2);
    tick();
    chk("end_valid", {63'h0, out_valid}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
